// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier (MULTU path): one partial product per BUSY cycle.
// Optional build macro MULT_EARLY_TERM_EN ends BUSY as soon as the remaining multiplier bits are zero.
//
//   state | meaning
//   IDLE  | waiting for Start
//   BUSY  | adding one partial product per cycle
//   DONE  | Product valid, Done pulse; Start here begins the next operation
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               load, early_stop, last_step;

  always_comb begin
    acc_sum   = mplier[0] ? (acc + mcand) : acc;
    last_step = (cnt == CNT_W'(1));
`ifdef MULT_EARLY_TERM_EN
    early_stop = (mplier == '0);
`else
    early_stop = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    Busy      = (state == BUSY);
    Done      = (state == DONE);
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (early_stop || last_step) state_nxt = DONE;
      end
      DONE: begin
        // Start in DONE is accepted so back-to-back operations have no gap
        if (Start) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      Product <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      cnt    <= CNT_W'(WIDTH);
    end else if (state == BUSY) begin
      if (early_stop) begin
        Product <= acc;
      end else begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        if (last_step) Product <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=32): directed corner cases plus
// randomized operands against an arithmetic reference; honours MULT_EARLY_TERM_EN for latency.
module tb_seq_shift_add_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           Start;
  logic [W-1:0]   A, B;
  logic           Busy, Done;
  logic [2*W-1:0] Product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] prev_product;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int exp_busy(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return (m + 2 > W) ? W : m + 2;
`else
    return W;
`endif
  endfunction

  // One complete operation; optionally pulses Start with other operands mid-BUSY.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                        input bit pulse_mid);
    int busy_n, guard;
    logic [2*W-1:0] exp;
    exp = 64'(a) * 64'(b);
    @(negedge clk);
    Start = 1'b1; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    busy_n = 0; guard = 0;
    while (!Done && guard < 100) begin
      if (Busy) busy_n++;
      if (guard == 0) check({tag, "_hold"}, Product, prev_product);
      if (pulse_mid && guard == 0) begin Start = 1'b1; A = $urandom; B = $urandom; end
      if (pulse_mid && guard == 1) Start = 1'b0;
      guard++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 64'(guard < 100), 64'd1);
    check({tag, "_product"}, Product, exp);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy(b)));
    prev_product = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int busy_n, guard, done_seen;
    logic [2*W-1:0] e1, e2;

    reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    prev_product = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {Product[61:0], Busy, Done}, 64'd0);
    check("reset_product", Product, 64'd0);
    reset = 1'b0;

    run_op(32'd5, 32'd3, "five_x_three", 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones", 1'b0);
    check("all_ones_value", Product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd0, 32'h1234_5678, "a_zero", 1'b0);
    run_op(32'hDEAD_BEEF, 32'd0, "b_zero", 1'b0);
    run_op(32'd7, 32'd3, "seven_x_three", 1'b0);
    run_op(32'h1357_9BDF, 32'h8000_0000, "b_msb", 1'b0);
    run_op(32'hCAFE_F00D, 32'h0000_1234, "start_ignored", 1'b1);

    for (int t = 0; t < 16; t++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, $sformatf("rand%0d", t), 1'b0);
    end

    // Start held high through DONE: second op must start with no idle cycle
    e1 = 64'(32'h0BAD_F00D) * 64'(32'h0000_FFFF);
    e2 = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
    @(negedge clk);
    Start = 1'b1; A = 32'h0BAD_F00D; B = 32'h0000_FFFF;
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    guard = 0;
    while (!Done && guard < 100) begin guard++; @(negedge clk); end
    check("b2b_first_timeout", 64'(guard < 100), 64'd1);
    check("b2b_first_product", Product, e1);
    @(negedge clk);
    Start = 1'b0;
    check("b2b_no_gap", {62'd0, Busy, Done}, 64'd2);
    busy_n = 1; guard = 0; done_seen = 0;
    @(negedge clk);
    while (!Done && guard < 100) begin
      if (Busy) busy_n++;
      guard++;
      @(negedge clk);
    end
    check("b2b_second_timeout", 64'(guard < 100), 64'd1);
    check("b2b_second_product", Product, e2);
    check("b2b_second_busy", 64'(busy_n), 64'(exp_busy(32'h9ABC_DEF0)));
    @(negedge clk);
    check("b2b_single_done", {62'd0, Busy, Done}, 64'd0);

    // reset mid-BUSY aborts with no Done and clears Product
    @(negedge clk);
    Start = 1'b1; A = 32'hFFFF_0001; B = 32'hFFFF_FFFF;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {62'd0, Busy, Done}, 64'd0);
    check("abort_product", Product, 64'd0);
    done_seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (Done || Busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    prev_product = '0;

    run_op(32'd5, 32'd3, "after_abort", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
